// File: rtl/neuron_pkg.sv
// Shared fixed-point definitions for the neuron datapath: Q1.15 activations,
// Q8.8 weights and Q8.24 pre-activation words.
package neuron_pkg;

  localparam int unsigned FRAC_BITS = 24;
  localparam int unsigned PRE_W     = 32;
  localparam int unsigned W_FRAC    = 8;

  localparam logic [PRE_W-1:0] Q824_MAX = 32'h7FFF_FFFF;
  localparam logic [PRE_W-1:0] Q824_MIN = 32'h8000_0000;

  typedef logic        [15:0]      act_t;
  typedef logic signed [15:0]      wgt_t;
  typedef logic signed [PRE_W-1:0] pre_t;

endpackage

// File: rtl/q824_sat.sv
// Combinational clamp of a wide signed Q.24 accumulator to a Q8.24 word,
// with an indicator that the value was out of range.
module q824_sat
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = 48
) (
  input  logic signed [ACC_W-1:0] acc,
  output pre_t                    data,
  output logic                    sat
);

  // In range only when every bit from 31 upward equals the sign bit.
  logic [ACC_W-32:0] upper;
  assign upper = acc[ACC_W-1:31];
  assign sat   = !((&upper) || !(|upper));

  always_comb begin
    data = pre_t'(acc[PRE_W-1:0]);
    if (sat) begin
      data = acc[ACC_W-1] ? pre_t'(Q824_MIN) : pre_t'(Q824_MAX);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming 3-stage multiply-accumulate neuron front end producing saturated
// Q8.24 pre-activations. Define NEURON_MAC_SAT_FLAG_EN for sat_flag/sat_sticky.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned X_W   = 16,
  parameter int unsigned W_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [X_W-1:0]        x_in,
  input  logic signed [W_W-1:0] w_in,
  input  pre_t                  bias_in,
  output logic                  in_ready,
  output logic                  out_valid,
  output pre_t                  out_data
`ifdef NEURON_MAC_SAT_FLAG_EN
  ,
  output logic                  sat_flag,
  output logic                  sat_sticky
`endif
);

  localparam int unsigned PROD_W     = X_W + W_W + 1;
  localparam int unsigned PROD_SHIFT = FRAC_BITS - ((X_W - 1) + W_FRAC);

  logic signed [PROD_W-1:0] prod_raw;
  logic signed [ACC_W-1:0]  s1_prod;
  pre_t                     s1_bias;
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic signed [ACC_W-1:0]  acc;
  logic                     s2_done;
  pre_t                     sat_data;
  logic                     sat_unused;

  assign in_ready = ~rst;

  // Activation is unsigned, so widen it with a zero sign bit before multiplying.
  assign prod_raw = PROD_W'($signed({1'b0, x_in})) * PROD_W'(w_in);

  // S1: product register, flags and bias capture on the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_valid & in_first;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        s1_prod <= ACC_W'(prod_raw) <<< PROD_SHIFT;
      end
      if (in_valid && in_first) begin
        s1_bias <= bias_in;
      end
    end
  end

  // S2: accumulate; a first beat reseeds from the bias and drops any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      s2_done <= 1'b0;
    end else begin
      s2_done <= s1_valid & s1_last;
      if (s1_valid) begin
        acc <= (s1_first ? ACC_W'(s1_bias) : acc) + s1_prod;
      end
    end
  end

  q824_sat #(
    .ACC_W(ACC_W)
  ) u_sat (
    .acc (acc),
    .data(sat_data),
    .sat (sat_unused)
  );

  // S3: clamped result, held until the next completed vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s2_done;
      if (s2_done) begin
        out_data <= sat_data;
      end
    end
  end

`ifdef NEURON_MAC_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag   <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      sat_flag <= s2_done & sat_unused;
      if (s2_done && sat_unused) begin
        sat_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// Directed, table-driven bench for neuron_mac with hand-computed Q8.24 results.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic [31:0] bias_in;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
`ifdef NEURON_MAC_SAT_FLAG_EN
  logic        sat_flag;
  logic        sat_sticky;
`endif

  neuron_mac dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_in  (bias_in),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data)
`ifdef NEURON_MAC_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag),
    .sat_sticky(sat_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] x;
    logic [15:0] w;
    logic [31:0] bias;
    logic [31:0] expd;
    logic        sat;
  } vec_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] d;
    logic        s;
  } ev_t;

  vec_t        tbl[10];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          proto_viol = 0;
  logic        in_vec = 1'b0;
  logic [31:0] hold_exp = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
`ifdef NEURON_MAC_SAT_FLAG_EN
      obs_q.push_back('{cyc, out_data, sat_flag});
`else
      obs_q.push_back('{cyc, out_data, 1'b0});
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one beat; a non-first beat outside a vector is a protocol violation.
  task automatic beat(input logic f, input logic l, input logic [15:0] x,
                      input logic [15:0] w, input logic [31:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = f; in_last = l;
    x_in = x; w_in = w; bias_in = b;
    if (!f && !in_vec) begin
      proto_viol++;
      $display("FAIL protocol: beat without in_first outside a vector at cycle %0d", cyc);
    end
    if (f) in_vec = 1'b1;
    if (l) in_vec = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic s);
    exp_q.push_back('{cyc + 3, d, s});
    hold_exp = d;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_vec = 1'b0;
    hold_exp = 32'h0;
    @(posedge clk); #1;
    check("in_ready_in_reset", 32'(in_ready), 32'h0);
    rst = 1'b0;
  endtask

  // Let the pipeline empty, then compare observed pulses against expectations.
  task automatic drain(input string name);
    ev_t e;
    ev_t o;
    repeat (8) idle();
    check({name, "_pulse_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, "_cycle"}, 32'(o.cyc), 32'(e.cyc));
      check({name, "_data"}, o.d, e.d);
`ifdef NEURON_MAC_SAT_FLAG_EN
      check({name, "_sat_flag"}, 32'(o.s), 32'(e.s));
`endif
    end
    exp_q.delete();
    obs_q.delete();
    check({name, "_hold"}, out_data, hold_exp);
    check({name, "_valid_low"}, 32'(out_valid), 32'h0);
  endtask

  initial begin
    tbl[0] = '{1, 16'h8000, 16'hFF80, 32'h0000_0000, 32'hFF80_0000, 1'b0};
    tbl[1] = '{1, 16'h4000, 16'h0080, 32'h0100_0000, 32'h0140_0000, 1'b0};
    tbl[2] = '{4, 16'h8000, 16'h7FFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    tbl[3] = '{2, 16'h8000, 16'h8000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[4] = '{1, 16'h0000, 16'h1234, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    tbl[5] = '{1, 16'h0000, 16'h1234, 32'h8000_0000, 32'h8000_0000, 1'b0};
    tbl[6] = '{1, 16'h0001, 16'h0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    tbl[7] = '{1, 16'h0001, 16'hFFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[8] = '{3, 16'h8000, 16'h0100, 32'h0000_0000, 32'h0300_0000, 1'b0};
    tbl[9] = '{2, 16'h6000, 16'hFE00, 32'h0080_0000, 32'hFD80_0000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    x_in = '0; w_in = '0; bias_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h0);
`ifdef NEURON_MAC_SAT_FLAG_EN
    check("reset_sat_sticky", 32'(sat_sticky), 32'h0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < tbl[i].n; b++) begin
        beat(b == 0, b == tbl[i].n - 1, tbl[i].x, tbl[i].w, tbl[i].bias);
      end
      expect_out(tbl[i].expd, tbl[i].sat);
      drain($sformatf("vec%0d", i));
    end
`ifdef NEURON_MAC_SAT_FLAG_EN
    check("sat_sticky_set", 32'(sat_sticky), 32'h1);
`endif

    // Back-to-back: 3-beat vector then a single-beat vector with no gap.
    beat(1'b1, 1'b0, 16'h8000, 16'h0100, 32'h0);
    beat(1'b0, 1'b0, 16'h8000, 16'h0100, 32'h0);
    beat(1'b0, 1'b1, 16'h8000, 16'h0100, 32'h0);
    expect_out(32'h0300_0000, 1'b0);
    beat(1'b1, 1'b1, 16'h2000, 16'h0200, 32'h0);
    expect_out(32'h0080_0000, 1'b0);
    drain("b2b");

    // in_first mid-vector restarts the sum: result is 2.0 + 1.0 only.
    beat(1'b1, 1'b0, 16'h8000, 16'h0100, 32'h0);
    beat(1'b0, 1'b0, 16'h8000, 16'h0100, 32'h0);
    beat(1'b1, 1'b0, 16'h8000, 16'h0200, 32'h0);
    beat(1'b0, 1'b1, 16'h8000, 16'h0100, 32'h0);
    expect_out(32'h0300_0000, 1'b0);
    drain("restart");

    // Reset after 2 of 4 beats, then a single-beat vector.
    beat(1'b1, 1'b0, 16'h8000, 16'h0100, 32'h0100_0000);
    beat(1'b0, 1'b0, 16'h8000, 16'h0100, 32'h0);
    pulse_rst();
`ifdef NEURON_MAC_SAT_FLAG_EN
    check("sat_sticky_cleared", 32'(sat_sticky), 32'h0);
`endif
    check("reset_mid_clears_data", out_data, 32'h0);
    beat(1'b1, 1'b1, 16'h8000, 16'h0280, 32'h0);
    expect_out(32'h0280_0000, 1'b0);
    drain("rst_mid");

    // Reset while a completed vector is still in flight: no pulse at all.
    beat(1'b1, 1'b1, 16'h8000, 16'h0100, 32'h0);
    pulse_rst();
    drain("rst_inflight");

    check("protocol_violations", 32'(proto_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
